conv_pool_collect: RTL and testbench
====================================

Name: conv_pool_collect

Overview:
- Downstream of the convolution engine. Captures each 16-bit signed window result when the engine pulses its done flag.
- Applies ReLU, then 2x2 stride-2 max pooling over the OUT_DIM x OUT_DIM convolution output map (raster order).
- Streams pooled values out over a valid/ready interface through a small FIFO. Signals end of frame.

Parameters:
- OUT_DIM, 4, side of conv output map; must be even, >=2
- DW, 16, data width of conv result and pooled output
- FIFO_DEPTH, 4, pooled-output FIFO entries; power of two, >=2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- conv_out  input  DW  signed two's-complement window sum from the conv stage
- conv_done  input  1  sample strobe from the conv stage; may stay high more than one cycle
- pool_data  output  DW  pooled value (unsigned after ReLU), FIFO head
- pool_valid  output  1  FIFO non-empty
- pool_ready  input  1  consumer accepts pool_data when pool_valid && pool_ready at clk edge
- frame_done  output  1  one-cycle pulse after last pooled value of a frame is popped
- overflow  output  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; row/col counters=0; line buffer, stage register, FIFO pointers and count=0. Outputs: pool_data=0, pool_valid=0, frame_done=0, overflow=0.
- Sample detect: register conv_done_d. sample = conv_done & ~conv_done_d. One sample per rising edge of conv_done, however long it is held.
- ReLU: relu = conv_out[DW-1] ? 0 : conv_out. So 0x8000 gives 0 and 0x7FFF passes unchanged.
- Stage 1, at the edge where sample=1 and state is IDLE or RUN:
  - Latch relu into stage_q; stage_v=1.
  - Latch the current (row, col) into stage_r, stage_c.
  - Advance col; on col=OUT_DIM-1, wrap col to 0 and increment row.
  - IDLE moves to RUN on the first sample.
- Stage 2, at the edge after stage_v=1 (comparisons unsigned):
  - Even row, even col: pair = stage_q.
  - Even row, odd col: lbuf[col/2] = max(pair, stage_q).
  - Odd row, even col: pair = max(lbuf[col/2], stage_q).
  - Odd row, odd col: push max(pair, stage_q) into the FIFO.
- Latency: sample at edge T, push at edge T+1, pool_valid high from T+1 if the FIFO was empty.
- FIFO:
  - Pop on pool_valid && pool_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Push when full with no pop: value dropped, overflow=1, held until reset.
  - pool_data shows the head entry. It is 0 when empty.
- Pooled outputs per frame: (OUT_DIM/2)^2, emitted row-major.
- State machine:
  - IDLE: wait for the first sample, then go to RUN.
  - RUN: when the sample at row=OUT_DIM-1, col=OUT_DIM-1 is captured, reset row/col to 0 and go to DRAIN.
  - DRAIN: wait until stage_v=0 and the FIFO is empty, then go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Samples arriving in DRAIN or DONE are discarded, and set overflow=1.
- Next frame starts with the first sample seen in IDLE.
- Reset mid-frame: all partial maxima and FIFO contents are lost. No frame_done.

Test Plan:
- Basic frame, OUT_DIM=4, pool_ready=1. 16 conv_done pulses carrying rows [5,0xFFFD,7,2], [1,9,0x8000,4], [10,20,30,40], [15,0xFFFF,100,3]. Required: pool_data sequence 9, 7, 20, 100; frame_done pulses once after 100 is popped; overflow=0.
- Latency: first odd-row/odd-col sample (value 9) strobed at edge T with empty FIFO. Required: pool_valid=1 and pool_data=9 immediately after edge T+1.
- Held strobe: conv_done held high for 5 cycles with conv_out=6. Required: exactly one sample captured (col advances by 1).
- Backpressure: pool_ready=0 for the whole basic frame, FIFO_DEPTH=4. Required: pool_valid stays 1 with 4 entries, overflow=0. Raising pool_ready drains 9, 7, 20, 100, then frame_done.
- Overflow: FIFO_DEPTH=2, pool_ready=0, basic frame. Required: values 20 and 100 are dropped, overflow=1 and stays set. Only 9 and 7 are popped later.
- Reset mid-frame: rst=0 asynchronously after 6 samples. Required: pool_valid=0 and overflow=0 immediately. A fresh full frame afterwards yields 9, 7, 20, 100 correctly.

Source files
------------

// File: rtl/conv_pool_collect_if.sv
// Stream bundle between the conv stage, the pooling collector and its consumer.
// The collector takes the slave view; whoever drives conv results and pool_ready takes the master view.
interface conv_pool_collect_if #(
    parameter int DW = 16
);
    logic [DW-1:0] conv_out;
    logic          conv_done;
    logic [DW-1:0] pool_data;
    logic          pool_valid;
    logic          pool_ready;
    logic          frame_done;
    logic          overflow;

    modport master (
        output conv_out, conv_done, pool_ready,
        input  pool_data, pool_valid, frame_done, overflow
    );

    modport slave (
        input  conv_out, conv_done, pool_ready,
        output pool_data, pool_valid, frame_done, overflow
    );
endinterface

// File: rtl/conv_pool_collect.sv
// Collects conv window results, applies ReLU and 2x2/stride-2 max pooling,
// and streams pooled values through a small FIFO with an end-of-frame pulse.
module conv_pool_collect #(
    parameter int OUT_DIM    = 4,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    conv_pool_collect_if.slave  bus
);
    localparam int CW  = (OUT_DIM > 2) ? $clog2(OUT_DIM) : 1;
    localparam int LW  = OUT_DIM / 2;
    localparam int LIW = (LW > 1) ? $clog2(LW) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(OUT_DIM - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t        state;
    logic          conv_done_d;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] stage_q;
    logic          stage_v;
    logic          stage_r_odd;
    logic [CW-1:0] stage_c;
    logic [DW-1:0] pair;
    logic [DW-1:0] lbuf [LW];
    logic [DW-1:0] mem  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          frame_done_reg;
    logic          overflow_reg;

    logic          sample;
    logic          take;
    logic          late_sample;
    logic [DW-1:0] relu;
    logic [LIW-1:0] lbuf_idx;
    logic          push_req;
    logic [DW-1:0] push_val;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;

    // Only the rising edge of conv_done counts, however long it is held.
    assign sample      = bus.conv_done & ~conv_done_d;
    assign take        = sample & ((state == IDLE) | (state == RUN));
    assign late_sample = sample & ((state == DRAIN) | (state == DONE));
    assign relu        = bus.conv_out[DW-1] ? '0 : bus.conv_out;

    generate
        if (OUT_DIM > 2) begin : g_lbuf_idx
            assign lbuf_idx = stage_c[CW-1:1];
        end else begin : g_lbuf_idx_single
            assign lbuf_idx = '0;
        end
    endgenerate

    assign push_req   = stage_v & stage_r_odd & stage_c[0];
    assign push_val   = umax(pair, stage_q);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = ~fifo_empty & bus.pool_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    assign bus.pool_valid = ~fifo_empty;
    assign bus.pool_data  = fifo_empty ? '0 : mem[rd_ptr];
    assign bus.frame_done = frame_done_reg;
    assign bus.overflow   = overflow_reg;

    // Frame sequencing, raster counters and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            row            <= '0;
            col            <= '0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (drop | late_sample) begin
                overflow_reg <= 1'b1;
            end
            case (state)
                IDLE: begin
                    frame_done_reg <= 1'b0;
                    if (take) begin
                        state <= RUN;
                        if (col == LAST_IDX) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (take) begin
                        if ((row == LAST_IDX) && (col == LAST_IDX)) begin
                            row   <= '0;
                            col   <= '0;
                            state <= DRAIN;
                        end else if (col == LAST_IDX) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!stage_v && fifo_empty) begin
                        state          <= DONE;
                        frame_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    frame_done_reg <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state          <= IDLE;
                    frame_done_reg <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the rectified sample with its map position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_done_d <= 1'b0;
            stage_q     <= '0;
            stage_v     <= 1'b0;
            stage_r_odd <= 1'b0;
            stage_c     <= '0;
        end else begin
            conv_done_d <= bus.conv_done;
            stage_v     <= take;
            if (take) begin
                stage_q     <= relu;
                stage_r_odd <= row[0];
                stage_c     <= col;
            end
        end
    end

    // Stage 2: even rows park the horizontal pair maximum in lbuf for the odd row below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair <= '0;
            for (int i = 0; i < LW; i++) begin
                lbuf[i] <= '0;
            end
        end else if (stage_v) begin
            case ({stage_r_odd, stage_c[0]})
                2'b00:   pair           <= stage_q;
                2'b01:   lbuf[lbuf_idx] <= umax(pair, stage_q);
                2'b10:   pair           <= umax(lbuf[lbuf_idx], stage_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_val;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_pool_collect.sv
// Directed bench: two collectors (FIFO depth 4 and 2) share one conv stimulus and one ready line.
module tb_conv_pool_collect;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] din  = '0;
    logic        dstb = 1'b0;
    logic        rdy  = 1'b0;

    conv_pool_collect_if #(.DW(16)) ia ();
    conv_pool_collect_if #(.DW(16)) ib ();

    assign ia.conv_out   = din;
    assign ia.conv_done  = dstb;
    assign ia.pool_ready = rdy;
    assign ib.conv_out   = din;
    assign ib.conv_done  = dstb;
    assign ib.pool_ready = rdy;

    conv_pool_collect #(.OUT_DIM(4), .DW(16), .FIFO_DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    conv_pool_collect #(.OUT_DIM(4), .DW(16), .FIFO_DEPTH(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    logic [15:0] frame [16] = '{16'd5, 16'hFFFD, 16'd7, 16'd2,
                                16'd1, 16'd9, 16'h8000, 16'd4,
                                16'd10, 16'd20, 16'd30, 16'd40,
                                16'd15, 16'hFFFF, 16'd100, 16'd3};
    int pooled [4] = '{9, 7, 20, 100};

    int total = 0;
    int bad   = 0;

    logic [15:0] qa [$];
    logic [15:0] qb [$];
    int fda = 0, fdb = 0, fdlen_a = 0, fdlen_b = 0;

    // Records what the next edge pops, plus frame_done pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (ia.pool_valid && rdy) qa.push_back(ia.pool_data);
            if (ib.pool_valid && rdy) qb.push_back(ib.pool_data);
            if (ia.frame_done) begin fda++; fdlen_a = qa.size(); end
            if (ib.frame_done) begin fdb++; fdlen_b = qb.size(); end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic send(input logic [15:0] v, input int hold);
        din  = v;
        dstb = 1'b1;
        repeat (hold) @(posedge clk);
        #1 dstb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        qa.delete();
        qb.delete();
        fda = 0; fdb = 0; fdlen_a = 0; fdlen_b = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", int'(ia.pool_valid), 0);
        chk("rst_data", int'(ia.pool_data), 0);
        chk("rst_fdone", int'(ia.frame_done), 0);
        chk("rst_ovf", int'(ib.overflow), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        clear_mon();
    endtask

    task automatic settle();
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic check_frame_a(input string tag);
        chk({tag, "_cnt"}, qa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_val%0d", tag, i), (i < qa.size()) ? int'(qa[i]) : -1, pooled[i]);
        end
        chk({tag, "_fd"}, fda, 1);
        chk({tag, "_fdlen"}, fdlen_a, 4);
        chk({tag, "_ovf"}, int'(ia.overflow), 0);
    endtask

    initial begin
        // Basic frame, including the first-push latency.
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) send(frame[i], 1);
        din  = frame[5];
        dstb = 1'b1;
        @(posedge clk);
        #1;
        chk("lat_pre_valid", int'(ia.pool_valid), 0);
        dstb = 1'b0;
        @(posedge clk);
        #1;
        chk("lat_valid", int'(ia.pool_valid), 1);
        chk("lat_data", int'(ia.pool_data), 9);
        for (int i = 6; i < 16; i++) send(frame[i], 1);
        settle();
        check_frame_a("basic");

        // Held strobe: first sample held five cycles must count once.
        do_reset();
        send(16'd6, 5);
        chk("held_nopush", int'(ia.pool_valid), 0);
        for (int i = 1; i < 16; i++) send(frame[i], 1);
        settle();
        check_frame_a("held");

        // Backpressure on depth 4, overflow on depth 2.
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 16; i++) send(frame[i], 1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_valid", int'(ia.pool_valid), 1);
        chk("bp_head", int'(ia.pool_data), 9);
        chk("bp_ovf_a", int'(ia.overflow), 0);
        chk("bp_nofd", fda, 0);
        chk("ovf_b", int'(ib.overflow), 1);
        rdy = 1'b1;
        settle();
        check_frame_a("bp");
        chk("ovf_b_cnt", qb.size(), 2);
        chk("ovf_b_val0", (qb.size() > 0) ? int'(qb[0]) : -1, 9);
        chk("ovf_b_val1", (qb.size() > 1) ? int'(qb[1]) : -1, 7);
        chk("ovf_b_sticky", int'(ib.overflow), 1);
        chk("ovf_b_fd", fdb, 1);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) send(frame[i], 1);
        chk("mid_pre_valid", int'(ia.pool_valid), 1);
        #3 rst = 1'b0;
        #1;
        chk("mid_valid", int'(ia.pool_valid), 0);
        chk("mid_ovf", int'(ia.overflow), 0);
        chk("mid_data", int'(ia.pool_data), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        clear_mon();
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) send(frame[i], 1);
        settle();
        check_frame_a("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
